// File: rtl/ibuf_serializer_if.sv
// Handshake and PE-side bundle for ibuf_serializer. The slave modport is the
// serializer side and the master modport is the word producer / array side.
interface ibuf_serializer_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4
);
  logic                    IValid;
  logic                    IReady;
  logic [LANES*DATA_W-1:0] IWord;
  logic                    Hold;
  logic                    Clear;
  logic [DATA_W-1:0]       OData;
  logic                    OValid;
  logic                    OLast;
  logic                    ENRight;
  logic                    ENDown;
  logic                    Busy;

  modport master (
    output IValid, IWord, Hold, Clear,
    input  IReady, OData, OValid, OLast, ENRight, ENDown, Busy
  );

  modport slave (
    input  IValid, IWord, Hold, Clear,
    output IReady, OData, OValid, OLast, ENRight, ENDown, Busy
  );
endinterface

// File: rtl/ibuf_serializer.sv
// Word-to-element serializer at the MAC array edge, with Hold stall and Clear abort.
// Define IBUF_LSB_FIRST_EN to emit lane 0 first; default emits lane LANES-1 first.
module ibuf_serializer #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4
) (
  input  logic               CLK,
  input  logic               RST,
  ibuf_serializer_if.slave   bus
);
  localparam int W  = LANES * DATA_W;
  localparam int CW = $clog2(LANES + 1);

  logic [W-1:0]      sh_q, sh_d, sh_nxt;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] odata_q, odata_d, emit;
  logic              ovalid_q, ovalid_d;
  logic              olast_q, olast_d;
  logic              enright_q, enright_d;
  logic              endown_q, endown_d;
  logic              ready, accept;

`ifdef IBUF_LSB_FIRST_EN
  assign emit   = sh_q[DATA_W-1:0];
  assign sh_nxt = sh_q >> DATA_W;
`else
  assign emit   = sh_q[W-1 -: DATA_W];
  assign sh_nxt = sh_q << DATA_W;
`endif

  // Ready with one element left so the next word loads as the last one leaves.
  assign ready  = !RST && !bus.Clear && !bus.Hold && (cnt_q <= CW'(1));
  assign accept = bus.IValid && ready;

  always_comb begin
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    odata_d   = odata_q;
    ovalid_d  = 1'b0;
    olast_d   = 1'b0;
    enright_d = 1'b0;
    endown_d  = ovalid_q;
    if (bus.Clear) begin
      sh_d    = '0;
      cnt_d   = '0;
      odata_d = '0;
    end else if (!bus.Hold) begin
      if (cnt_q != '0) begin
        odata_d  = emit;
        ovalid_d = 1'b1;
        olast_d  = (cnt_q == CW'(1));
        sh_d     = sh_nxt;
        cnt_d    = cnt_q - CW'(1);
      end
      if (accept) begin
        sh_d  = bus.IWord;
        cnt_d = CW'(LANES);
      end
      enright_d = accept;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sh_q      <= '0;
      cnt_q     <= '0;
      odata_q   <= '0;
      ovalid_q  <= 1'b0;
      olast_q   <= 1'b0;
      enright_q <= 1'b0;
      endown_q  <= 1'b0;
    end else begin
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      odata_q   <= odata_d;
      ovalid_q  <= ovalid_d;
      olast_q   <= olast_d;
      enright_q <= enright_d;
      endown_q  <= endown_d;
    end
  end

  assign bus.IReady  = ready;
  assign bus.OData   = odata_q;
  assign bus.OValid  = ovalid_q;
  assign bus.OLast   = olast_q;
  assign bus.ENRight = enright_q;
  assign bus.ENDown  = endown_q;
  assign bus.Busy    = (cnt_q != '0);
endmodule

// File: tb/tb_ibuf_serializer.sv
// Directed bench for ibuf_serializer: a LANES=4 instance and a LANES=1 instance.
module tb_ibuf_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  ibuf_serializer_if #(.DATA_W(8), .LANES(4)) bus  ();
  ibuf_serializer_if #(.DATA_W(8), .LANES(1)) bus1 ();

  ibuf_serializer #(.DATA_W(8), .LANES(4)) u_dut  (.CLK(clk), .RST(rst), .bus(bus.slave));
  ibuf_serializer #(.DATA_W(8), .LANES(1)) u_dut1 (.CLK(clk), .RST(rst), .bus(bus1.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // i-th element emitted from a 4-lane word
  function automatic logic [7:0] lane(input logic [31:0] w, input int i);
`ifdef IBUF_LSB_FIRST_EN
    return w[8*i +: 8];
`else
    return w[8*(3-i) +: 8];
`endif
  endfunction

  task automatic chk_o(input string tag, input logic [7:0] d, input logic v, input logic l);
    chk({tag, ".odata"},  32'(bus.OData),  32'(d));
    chk({tag, ".ovalid"}, 32'(bus.OValid), 32'(v));
    chk({tag, ".olast"},  32'(bus.OLast),  32'(l));
  endtask

  task automatic send(input logic [31:0] w);
    bus.IValid = 1'b1;
    bus.IWord  = w;
    #1;
    chk("send.iready", 32'(bus.IReady), 32'd1);
    tick();
    bus.IValid = 1'b0;
    chk("send.enright", 32'(bus.ENRight), 32'd1);
    chk("send.busy",    32'(bus.Busy),    32'd1);
  endtask

  logic [31:0] w1, w2;

  initial begin
    bus.IValid = 0; bus.IWord = '0; bus.Hold = 0; bus.Clear = 0;
    bus1.IValid = 0; bus1.IWord = '0; bus1.Hold = 0; bus1.Clear = 0;

    // reset state
    tick(); tick();
    chk("rst.iready", 32'(bus.IReady), 32'd0);
    chk_o("rst", 8'h00, 1'b0, 1'b0);
    chk("rst.enright", 32'(bus.ENRight), 32'd0);
    chk("rst.endown",  32'(bus.ENDown),  32'd0);
    chk("rst.busy",    32'(bus.Busy),    32'd0);
    rst = 1'b0;
    #1;
    chk("idle.iready", 32'(bus.IReady), 32'd1);

    // single word
    w1 = 32'hA1B2C3D4;
    send(w1);
    chk_o("sw.k", 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_o($sformatf("sw.e%0d", i), lane(w1, i), 1'b1, i == 3);
      chk($sformatf("sw.endown%0d", i), 32'(bus.ENDown), 32'(i != 0));
      chk($sformatf("sw.enright%0d", i), 32'(bus.ENRight), 32'd0);
    end
    chk("sw.busy_end", 32'(bus.Busy), 32'd0);
    tick();
    chk_o("sw.after", lane(w1, 3), 1'b0, 1'b0);
    chk("sw.endown_tail", 32'(bus.ENDown), 32'd1);
    tick();
    chk("sw.endown_off", 32'(bus.ENDown), 32'd0);

    // back-to-back
    w1 = 32'h11223344; w2 = 32'h55667788;
    bus.IValid = 1'b1; bus.IWord = w1;
    #1;
    chk("bb.ready0", 32'(bus.IReady), 32'd1);
    tick();
    bus.IWord = w2;
    chk("bb.ready_a", 32'(bus.IReady), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_o($sformatf("bb.w1e%0d", i), lane(w1, i), 1'b1, i == 3);
      chk($sformatf("bb.ready%0d", i), 32'(bus.IReady), 32'(i == 2));
    end
    chk("bb.enright2", 32'(bus.ENRight), 32'd1);
    bus.IValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_o($sformatf("bb.w2e%0d", i), lane(w2, i), 1'b1, i == 3);
    end
    tick();
    chk_o("bb.after", lane(w2, 3), 1'b0, 1'b0);

    // hold while idle blocks acceptance
    bus.Hold = 1'b1; bus.IValid = 1'b1; bus.IWord = 32'hDEADBEEF;
    #1;
    chk("hidle.iready", 32'(bus.IReady), 32'd0);
    tick();
    chk("hidle.enright", 32'(bus.ENRight), 32'd0);
    chk("hidle.busy",    32'(bus.Busy),    32'd0);
    bus.Hold = 1'b0; bus.IValid = 1'b0;

    // hold mid-word for 2 cycles after the second element
    w1 = 32'hA1B2C3D4;
    send(w1);
    tick(); tick();
    chk_o("hold.e1", lane(w1, 1), 1'b1, 1'b0);
    bus.Hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("hold.iready%0d", i), 32'(bus.IReady), 32'd0);
      tick();
      chk_o($sformatf("hold.h%0d", i), lane(w1, 1), 1'b0, 1'b0);
      chk($sformatf("hold.busy%0d", i), 32'(bus.Busy), 32'd1);
    end
    bus.Hold = 1'b0;
    tick();
    chk_o("hold.e2", lane(w1, 2), 1'b1, 1'b0);
    tick();
    chk_o("hold.e3", lane(w1, 3), 1'b1, 1'b1);
    tick();
    chk_o("hold.after", lane(w1, 3), 1'b0, 1'b0);

    // clear mid-word with a competing word
    send(w1);
    tick(); tick();
    bus.Clear = 1'b1; bus.IValid = 1'b1; bus.IWord = 32'h99AABBCC;
    #1;
    chk("clr.iready", 32'(bus.IReady), 32'd0);
    tick();
    bus.Clear = 1'b0; bus.IValid = 1'b0;
    chk_o("clr", 8'h00, 1'b0, 1'b0);
    chk("clr.busy",    32'(bus.Busy),    32'd0);
    chk("clr.enright", 32'(bus.ENRight), 32'd0);
    chk("clr.endown",  32'(bus.ENDown),  32'd1);
    tick();
    chk_o("clr.idle", 8'h00, 1'b0, 1'b0);
    chk("clr.endown2", 32'(bus.ENDown), 32'd0);
    w2 = 32'h0F1E2D3C;
    send(w2);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_o($sformatf("clr.n%0d", i), lane(w2, i), 1'b1, i == 3);
    end
    tick();

    // reset mid-word
    send(w1);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("mrst.iready", 32'(bus.IReady), 32'd0);
    tick();
    chk_o("mrst", 8'h00, 1'b0, 1'b0);
    chk("mrst.enright", 32'(bus.ENRight), 32'd0);
    chk("mrst.endown",  32'(bus.ENDown),  32'd0);
    chk("mrst.busy",    32'(bus.Busy),    32'd0);
    rst = 1'b0;
    tick();
    chk("mrst.stay", 32'(bus.OValid), 32'd0);

    // LANES=1 continuous stream
    bus1.IValid = 1'b1; bus1.IWord = 8'h01;
    #1;
    chk("l1.ready0", 32'(bus1.IReady), 32'd1);
    tick();
    bus1.IWord = 8'h02;
    chk("l1.ready1", 32'(bus1.IReady), 32'd1);
    tick();
    bus1.IWord = 8'h03;
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("l1.d%0d", i), 32'(bus1.OData), 32'(i));
      chk($sformatf("l1.v%0d", i), 32'(bus1.OValid), 32'd1);
      chk($sformatf("l1.l%0d", i), 32'(bus1.OLast), 32'd1);
      if (i == 2) bus1.IValid = 1'b0;
      tick();
    end
    chk("l1.after_v", 32'(bus1.OValid), 32'd0);
    chk("l1.after_l", 32'(bus1.OLast),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
